// File: rtl/data_mem_responder.sv
// Data memory responder: single-outstanding req/rsp slave with WAIT_CYCLES wait states and byte-lane stores.
// Define DATA_MEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses as errors instead of aligning them down.
module data_mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    localparam int         DEPTH     = 1 << (ADDR_WIDTH - 2);
    localparam int         LANES     = DATA_WIDTH / 8;
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic                  lat_we;
    logic                  lat_uns;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [1:0]            lat_size;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  a_we;
    logic                  a_uns;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [1:0]            a_size;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  enter_resp;

    // With zero wait states the access happens on the accept edge, so it must use the live request.
    always_comb begin
        if (state == ST_IDLE) begin
            a_we    = req_we;
            a_uns   = req_unsigned;
            a_addr  = req_addr;
            a_size  = req_size;
            a_wdata = req_wdata;
        end else begin
            a_we    = lat_we;
            a_uns   = lat_uns;
            a_addr  = lat_addr;
            a_size  = lat_size;
            a_wdata = lat_wdata;
        end
        enter_resp = (NO_WAIT && state == ST_IDLE && req_valid) ||
                     (state == ST_WAIT && cnt == 4'd0);
    end

    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [LANES-1:0]      be;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic                  ext;
    logic                  misalign;
    logic                  acc_err;

    always_comb begin
        rd_word  = mem[a_addr[ADDR_WIDTH-1:2]];
        ld_byte  = rd_word[{a_addr[1:0], 3'b000} +: 8];
        ld_half  = rd_word[{a_addr[1], 4'b0000} +: 16];
        ld_data  = '0;
        wr_data  = '0;
        be       = '0;
        ext      = 1'b0;
        misalign = 1'b0;
`ifdef DATA_MEM_MISALIGN_CHECK_EN
        misalign = (a_size == 2'b01 && a_addr[0]) ||
                   (a_size == 2'b10 && a_addr[1:0] != 2'b00);
`endif
        acc_err  = (a_size == 2'b11) || misalign;
        case (a_size)
            2'b00: begin
                be[a_addr[1:0]] = 1'b1;
                wr_data         = {LANES{a_wdata[7:0]}};
                ext             = ~a_uns & ld_byte[7];
                ld_data         = {{(DATA_WIDTH-8){ext}}, ld_byte};
            end
            2'b01: begin
                be[{a_addr[1], 1'b0} +: 2] = 2'b11;
                wr_data                    = {(LANES/2){a_wdata[15:0]}};
                ext                        = ~a_uns & ld_half[15];
                ld_data                    = {{(DATA_WIDTH-16){ext}}, ld_half};
            end
            2'b10: begin
                be      = '1;
                wr_data = a_wdata;
                ld_data = rd_word;
            end
            default: ;
        endcase
    end

    // NOTE: the storage array has no reset; only control and output registers are cleared.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && a_we && !acc_err) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) mem[a_addr[ADDR_WIDTH-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_addr  <= '0;
            lat_size  <= 2'b00;
            lat_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_uns   <= req_unsigned;
                        lat_addr  <= req_addr;
                        lat_size  <= req_size;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        cnt       <= WAIT_LOAD;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Entry into RESP overrides the per-state updates above.
            if (enter_resp) begin
                state     <= ST_RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= (a_we || acc_err) ? '0 : ld_data;
            end
        end
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus and word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, byte-address width; storage depth is 2^(ADDR_WIDTH-2) words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted between request accept and response (legal range 0..15).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  CPU request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  ADDR_WIDTH  byte address.
REQ-010 req_size  input  2  00 byte, 01 half, 10 word; 11 reserved.
REQ-011 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  CPU accepts response.
REQ-015 rsp_rdata  output  DATA_WIDTH  load data, extended per req_size/req_unsigned; 0 for stores.
REQ-016 rsp_err  output  1  access error flag, valid with rsp_valid.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-018 IDLE: req_ready=1; request accepted on the cycle req_valid=1; latch we, addr, size, unsigned, wdata.
REQ-019 On accept: go to WAIT with wait counter loaded to WAIT_CYCLES-1, or directly to RESP when WAIT_CYCLES=0.
REQ-020 WAIT: req_ready=0; decrement counter each cycle; go to RESP on the cycle the counter reaches 0.
REQ-021 Memory access SHALL be performed on the cycle of entry to RESP; store writes only the addressed byte lanes (byte/half/word enables from addr[1:0] and size).
REQ-022 RESP: rsp_valid=1; rsp_rdata, rsp_err held stable until rsp_ready=1; then return to IDLE.
REQ-023 Accept-to-rsp_valid latency SHALL equal WAIT_CYCLES+1 clocks.
REQ-024 req_ready SHALL be 0 in WAIT and RESP; no request is accepted until the cycle after rsp handshake (no overlap).
REQ-025 Load data: byte/half selected by addr[1:0] and addr[1], then sign- or zero-extended to DATA_WIDTH.
REQ-026 A load following a store to the same address SHALL return the stored data.
REQ-027 req_size=11 SHALL set rsp_err=1, perform no write, and return rdata=0.
REQ-028 Addresses wrap modulo 2^ADDR_WIDTH; no out-of-range condition exists.

Reset
REQ-029 rst low SHALL asynchronously force state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-030 Reset mid-transaction SHALL abandon it; a store not yet in RESP SHALL NOT write memory.
REQ-031 Memory array contents are not reset.

Configuration
REQ-032 Macro DATA_MEM_MISALIGN_CHECK_EN enables alignment checking.
REQ-033 With macro defined: half access with addr[0]=1 or word access with addr[1:0]!=00 SHALL set rsp_err=1, perform no write, return rdata=0.
REQ-034 Without macro: misaligned addresses SHALL be aligned down to the access size (low bits ignored), rsp_err=0 except per REQ-027.

Verification
REQ-035 Reset, WAIT_CYCLES=2: store word 0xDEADBEEF at 0x010 -> rsp_valid rises 3 clocks after accept, rsp_err=0; load word 0x010 -> rdata=0xDEADBEEF.
REQ-036 Store byte 0x80 at 0x013, load byte signed 0x013 -> rdata=0xFFFFFF80; unsigned -> 0x00000080; load word 0x010 -> 0x80ADBEEF.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata stable, req_ready=0, new req_valid ignored; accepted one cycle after handshake.
REQ-038 Drive rst low during WAIT of a store to 0x020 -> outputs at reset values immediately; later load 0x020 returns prior contents.
REQ-039 Half load at 0x011: with DATA_MEM_MISALIGN_CHECK_EN -> rsp_err=1, rdata=0; without -> rsp_err=0, data from 0x010.
REQ-040 WAIT_CYCLES=0: back-to-back requests -> rsp_valid one clock after each accept; req_size=11 -> rsp_err=1.
